// File: rtl/puck_sequencer_if.sv
// Handshake and data bundle between the frame controller and its environment.
// master: the side that drives frame_tick, serve and paddle positions.
// slave:  the sequencer, which drives puck state, scores and status flags.
interface puck_sequencer_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_x_1;
  logic [9:0] paddle_y_1;
  logic [9:0] paddle_x_2;
  logic [9:0] paddle_y_2;
  logic [9:0] puck_x;
  logic [9:0] puck_y;
  logic [4:0] vel_x;
  logic [4:0] vel_y;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       goal;
  logic       busy;
  logic       overrun;
  logic       game_over;

  modport master (
    output frame_tick, serve, paddle_x_1, paddle_y_1, paddle_x_2, paddle_y_2,
    input  puck_x, puck_y, vel_x, vel_y, score_1, score_2,
    input  goal, busy, overrun, game_over
  );

  modport slave (
    input  frame_tick, serve, paddle_x_1, paddle_y_1, paddle_x_2, paddle_y_2,
    output puck_x, puck_y, vel_x, vel_y, score_1, score_2,
    output goal, busy, overrun, game_over
  );
endinterface

// File: rtl/puck_sequencer.sv
// puck_sequencer: per-frame air-hockey puck controller.
// Each accepted frame_tick walks LATCH -> MOVE -> WALL -> HIT1 -> HIT2 -> COMMIT,
// advancing the puck, resolving wall bounces / goals and paddle contacts.
// Both paddle checks share one squared-distance unit selected by state.
// Optional feature: define PUCK_FRICTION_EN to slow the puck every 64th frame.
module puck_sequencer #(
  parameter int X_MIN     = 194,
  parameter int X_MAX     = 734,
  parameter int Y_MIN     = 71,
  parameter int Y_MAX     = 471,
  parameter int GOAL_LO   = 221,
  parameter int GOAL_HI   = 321,
  parameter int PUCK_R    = 10,
  parameter int HIT_D2    = 625,
  parameter int SERVE_VX  = 3,
  parameter int SERVE_VY  = 2,
  parameter int MAX_SPEED = 7,
  parameter int WIN_SCORE = 7
) (
  input  logic            clk,
  input  logic            clr_n,
  puck_sequencer_if.slave bus
);

  localparam logic [9:0]         X_CTR   = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0]         Y_CTR   = 10'((Y_MIN + Y_MAX) / 2);
  localparam logic signed [10:0] X_LO    = 11'(X_MIN + PUCK_R);
  localparam logic signed [10:0] X_HI    = 11'(X_MAX - PUCK_R);
  localparam logic signed [10:0] Y_LO    = 11'(Y_MIN + PUCK_R);
  localparam logic signed [10:0] Y_HI    = 11'(Y_MAX - PUCK_R);
  localparam logic signed [10:0] G_LO    = 11'(GOAL_LO);
  localparam logic signed [10:0] G_HI    = 11'(GOAL_HI);
  localparam logic [21:0]        HIT_LIM = 22'(HIT_D2);
  localparam logic [4:0]         SPD_MAX = 5'(MAX_SPEED);
  localparam logic [4:0]         SRV_VX  = 5'(SERVE_VX);
  localparam logic [4:0]         SRV_VY  = 5'(SERVE_VY);
  localparam logic [3:0]         WIN     = 4'(WIN_SCORE);

  typedef enum logic [3:0] {
    S_SERVE, S_IDLE, S_LATCH, S_MOVE, S_WALL, S_HIT1, S_HIT2, S_COMMIT, S_OVER
  } state_t;

  // Speed up a two's-complement velocity by one step (capped), with new sign.
  function automatic logic [4:0] speed_up(input logic [4:0] v, input logic neg);
    logic [4:0] mag;
    logic [4:0] inc;
    mag = v[4] ? (5'd0 - v) : v;
    if (mag >= SPD_MAX) inc = SPD_MAX;
    else                inc = mag + 5'd1;
    speed_up = neg ? (5'd0 - inc) : inc;
  endfunction

  // Saturating score increment.
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    score_inc = (s == 4'hF) ? s : (s + 4'd1);
  endfunction

`ifdef PUCK_FRICTION_EN
  // Reduce a nonzero velocity magnitude by one, never below one.
  function automatic logic [4:0] slow_down(input logic [4:0] v);
    if (v == 5'd0 || v == 5'd1 || v == 5'h1F) slow_down = v;
    else if (v[4])                            slow_down = v + 5'd1;
    else                                      slow_down = v - 5'd1;
  endfunction
`endif

  state_t             r_state;
  logic [9:0]         r_puck_x, r_puck_y;
  logic [4:0]         r_vel_x, r_vel_y;
  logic [3:0]         r_score_1, r_score_2;
  logic               r_goal, r_busy, r_overrun, r_game_over;
  logic               r_serve_left;
  logic [9:0]         r_px1, r_py1, r_px2, r_py2;
  logic signed [10:0] r_nx, r_ny;
  logic [4:0]         r_wvx, r_wvy;
`ifdef PUCK_FRICTION_EN
  logic [5:0]         r_fric_cnt;
  logic               r_fric_now;
`endif

  logic               w_left, w_right, w_mouth, w_goal_1, w_goal_2;
  logic signed [10:0] w_wall_nx, w_wall_ny;
  logic [4:0]         w_wall_vx, w_wall_vy;
  logic [9:0]         w_pad_x, w_pad_y;
  logic signed [10:0] w_dx, w_dy;
  logic [10:0]        w_adx, w_ady;
  logic [21:0]        w_d2;
  logic               w_hit;
  logic [4:0]         w_hit_vx, w_hit_vy;
  logic               w_in_frame;
  logic [3:0]         w_new_s1, w_new_s2;

  // Wall and goal resolution on the freshly moved position.
  always_comb begin
    w_left   = (r_nx <= X_LO);
    w_right  = (r_nx >= X_HI);
    w_mouth  = (r_ny >= G_LO) && (r_ny <= G_HI);
    w_goal_1 = w_right && w_mouth;
    w_goal_2 = w_left && w_mouth;
    w_new_s1 = score_inc(r_score_1);
    w_new_s2 = score_inc(r_score_2);
    if (w_left) begin
      w_wall_nx = X_LO;
      w_wall_vx = 5'd0 - r_wvx;
    end else if (w_right) begin
      w_wall_nx = X_HI;
      w_wall_vx = 5'd0 - r_wvx;
    end else begin
      w_wall_nx = r_nx;
      w_wall_vx = r_wvx;
    end
    if (r_ny <= Y_LO) begin
      w_wall_ny = Y_LO;
      w_wall_vy = 5'd0 - r_wvy;
    end else if (r_ny >= Y_HI) begin
      w_wall_ny = Y_HI;
      w_wall_vy = 5'd0 - r_wvy;
    end else begin
      w_wall_ny = r_ny;
      w_wall_vy = r_wvy;
    end
  end

  // Shared squared-distance unit: paddle 2 in HIT2, paddle 1 otherwise.
  always_comb begin
    if (r_state == S_HIT2) begin
      w_pad_x = r_px2;
      w_pad_y = r_py2;
    end else begin
      w_pad_x = r_px1;
      w_pad_y = r_py1;
    end
    w_dx  = r_nx - $signed({1'b0, w_pad_x});
    w_dy  = r_ny - $signed({1'b0, w_pad_y});
    w_adx = w_dx[10] ? (11'd0 - w_dx) : w_dx;
    w_ady = w_dy[10] ? (11'd0 - w_dy) : w_dy;
    w_d2  = ({11'd0, w_adx} * {11'd0, w_adx}) + ({11'd0, w_ady} * {11'd0, w_ady});
    w_hit = (w_d2 < HIT_LIM);
    if (w_hit) begin
      w_hit_vx = speed_up(r_wvx, w_dx[10]);
      w_hit_vy = speed_up(r_wvy, w_dy[10]);
    end else begin
      w_hit_vx = r_wvx;
      w_hit_vy = r_wvy;
    end
  end

  // States in which an incoming frame_tick cannot be accepted.
  always_comb begin
    w_in_frame = (r_state == S_LATCH) || (r_state == S_MOVE) || (r_state == S_WALL) ||
                 (r_state == S_HIT1) || (r_state == S_HIT2) || (r_state == S_COMMIT);
  end

  // Frame sequencer: state, puck/score registers and all registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_SERVE;
      r_puck_x     <= X_CTR;
      r_puck_y     <= Y_CTR;
      r_vel_x      <= 5'd0;
      r_vel_y      <= 5'd0;
      r_score_1    <= 4'd0;
      r_score_2    <= 4'd0;
      r_goal       <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_game_over  <= 1'b0;
      r_serve_left <= 1'b0;
      r_px1        <= 10'd0;
      r_py1        <= 10'd0;
      r_px2        <= 10'd0;
      r_py2        <= 10'd0;
      r_nx         <= 11'sd0;
      r_ny         <= 11'sd0;
      r_wvx        <= 5'd0;
      r_wvy        <= 5'd0;
`ifdef PUCK_FRICTION_EN
      r_fric_cnt   <= 6'd0;
      r_fric_now   <= 1'b0;
`endif
    end else begin
      r_goal <= 1'b0;
      if (bus.frame_tick && w_in_frame) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_SERVE: begin
          r_puck_x <= X_CTR;
          r_puck_y <= Y_CTR;
          if (bus.serve) begin
            r_vel_x <= r_serve_left ? (5'd0 - SRV_VX) : SRV_VX;
            r_vel_y <= SRV_VY;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (bus.frame_tick) begin
            r_busy  <= 1'b1;
            r_state <= S_LATCH;
`ifdef PUCK_FRICTION_EN
            r_fric_now <= (r_fric_cnt == 6'd63);
            r_fric_cnt <= r_fric_cnt + 6'd1;
`endif
          end
        end
        S_LATCH: begin
          r_px1   <= bus.paddle_x_1;
          r_py1   <= bus.paddle_y_1;
          r_px2   <= bus.paddle_x_2;
          r_py2   <= bus.paddle_y_2;
          r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_nx    <= $signed({1'b0, r_puck_x}) + $signed({{6{r_vel_x[4]}}, r_vel_x});
          r_ny    <= $signed({1'b0, r_puck_y}) + $signed({{6{r_vel_y[4]}}, r_vel_y});
`ifdef PUCK_FRICTION_EN
          r_wvx   <= r_fric_now ? slow_down(r_vel_x) : r_vel_x;
          r_wvy   <= r_fric_now ? slow_down(r_vel_y) : r_vel_y;
`else
          r_wvx   <= r_vel_x;
          r_wvy   <= r_vel_y;
`endif
          r_state <= S_WALL;
        end
        S_WALL: begin
          if (w_goal_1 || w_goal_2) begin
            // A goal abandons the frame: recentre, stop, and hand the serve
            // to the side that conceded.
            r_goal   <= 1'b1;
            r_busy   <= 1'b0;
            r_puck_x <= X_CTR;
            r_puck_y <= Y_CTR;
            r_vel_x  <= 5'd0;
            r_vel_y  <= 5'd0;
`ifdef PUCK_FRICTION_EN
            r_fric_cnt <= 6'd0;
`endif
            if (w_goal_1) begin
              r_score_1    <= w_new_s1;
              r_serve_left <= 1'b0;
              if (w_new_s1 == WIN) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_SERVE;
              end
            end else begin
              r_score_2    <= w_new_s2;
              r_serve_left <= 1'b1;
              if (w_new_s2 == WIN) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_SERVE;
              end
            end
          end else begin
            r_nx    <= w_wall_nx;
            r_ny    <= w_wall_ny;
            r_wvx   <= w_wall_vx;
            r_wvy   <= w_wall_vy;
            r_state <= S_HIT1;
          end
        end
        S_HIT1: begin
          r_wvx   <= w_hit_vx;
          r_wvy   <= w_hit_vy;
          r_state <= S_HIT2;
        end
        S_HIT2: begin
          r_wvx   <= w_hit_vx;
          r_wvy   <= w_hit_vy;
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_puck_x <= r_nx[9:0];
          r_puck_y <= r_ny[9:0];
          r_vel_x  <= r_wvx;
          r_vel_y  <= r_wvy;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_OVER: begin
          r_game_over <= 1'b1;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_SERVE;
        end
      endcase
    end
  end

  assign bus.puck_x    = r_puck_x;
  assign bus.puck_y    = r_puck_y;
  assign bus.vel_x     = r_vel_x;
  assign bus.vel_y     = r_vel_y;
  assign bus.score_1   = r_score_1;
  assign bus.score_2   = r_score_2;
  assign bus.goal      = r_goal;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;
  assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_puck_sequencer.sv
// Directed bench for puck_sequencer. Puck trajectories are steered with
// paddle placements so that wall bounces, paddle hits and goals land on
// hand-computed frames.
module tb_puck_sequencer;
  logic clk;
  logic clr_n;
  int   checks;
  int   failures;
  int   goal_seen;
  int   busy_seen;

  puck_sequencer_if bus ();

  puck_sequencer dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame per iteration: tick at a negedge, then 9 sampled negedges.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      bus.frame_tick = 1'b1;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (bus.goal === 1'b1) goal_seen++;
        if (bus.busy === 1'b1) busy_seen++;
      end
    end
  endtask

  task automatic set_pads(input logic [9:0] x1, input logic [9:0] y1,
                          input logic [9:0] x2, input logic [9:0] y2);
    bus.paddle_x_1 = x1;
    bus.paddle_y_1 = y1;
    bus.paddle_x_2 = x2;
    bus.paddle_y_2 = y2;
  endtask

  task automatic do_serve();
    bus.serve = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    goal_seen  = 0;
    busy_seen  = 0;
    bus.frame_tick = 1'b0;
    bus.serve      = 1'b0;
    set_pads(10'd0, 10'd0, 10'd0, 10'd0);
    clr_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_puck_x", bus.puck_x, 32'd464);
    check("rst_puck_y", bus.puck_y, 32'd271);
    check("rst_vel_x", bus.vel_x, 32'd0);
    check("rst_vel_y", bus.vel_y, 32'd0);
    check("rst_scores", {bus.score_1, bus.score_2}, 32'd0);
    check("rst_flags", {bus.goal, bus.busy, bus.overrun, bus.game_over}, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // Ticks are ignored before the serve
    busy_seen = 0;
    run_frames(1);
    check("serve_wait_busy", busy_seen, 32'd0);
    check("serve_wait_x", bus.puck_x, 32'd464);

    // Serve and first frame
    do_serve();
    check("serve_vx", bus.vel_x, 32'd3);
    check("serve_vy", bus.vel_y, 32'd2);
    busy_seen = 0;
    run_frames(1);
    check("f1_busy_cycles", busy_seen, 32'd6);
    check("f1_puck_x", bus.puck_x, 32'd467);
    check("f1_puck_y", bus.puck_y, 32'd273);

    // Frame 40: paddle 2 alone turns the puck left
    run_frames(38);
    set_pads(10'd0, 10'd0, 10'd588, 10'd347);
    run_frames(1);
    set_pads(10'd0, 10'd0, 10'd0, 10'd0);
    check("p2hit_x", bus.puck_x, 32'd584);
    check("p2hit_y", bus.puck_y, 32'd351);
    check("p2hit_vx", bus.vel_x, 32'h1C);
    check("p2hit_vy", bus.vel_y, 32'd3);

    // Bottom bounce on the way, then just short of the left goal
    run_frames(94);
    check("pre_lgoal_x", bus.puck_x, 32'd208);
    check("pre_lgoal_y", bus.puck_y, 32'd290);
    check("pre_lgoal_vy", bus.vel_y, 32'h1D);

    // Left goal for player 2
    goal_seen = 0;
    run_frames(1);
    check("lgoal_pulse", goal_seen, 32'd1);
    check("lgoal_score2", bus.score_2, 32'd1);
    check("lgoal_score1", bus.score_1, 32'd0);
    check("lgoal_x", bus.puck_x, 32'd464);
    check("lgoal_y", bus.puck_y, 32'd271);
    check("lgoal_v", {bus.vel_x, bus.vel_y}, 32'd0);
    check("lgoal_busy", bus.busy, 32'd0);

    // Serve goes toward the side that conceded
    do_serve();
    check("serve2_vx", bus.vel_x, 32'h1D);
    check("serve2_vy", bus.vel_y, 32'd2);

    // Left wall bounce outside the goal mouth
    goal_seen = 0;
    run_frames(87);
    check("lwall_goal", goal_seen, 32'd0);
    check("lwall_x", bus.puck_x, 32'd204);
    check("lwall_y", bus.puck_y, 32'd445);
    check("lwall_vx", bus.vel_x, 32'd3);

    // Paddle 1 hit, dy = 0 counts as positive
    set_pads(10'd200, 10'd447, 10'd0, 10'd0);
    run_frames(1);
    check("p1hit_x", bus.puck_x, 32'd207);
    check("p1hit_vx", bus.vel_x, 32'd4);
    check("p1hit_vy", bus.vel_y, 32'd3);

    // Both paddles overlap: paddle 2 acts on the paddle 1 result
    set_pads(10'd205, 10'd450, 10'd215, 10'd455);
    run_frames(1);
    set_pads(10'd0, 10'd0, 10'd0, 10'd0);
    check("both_x", bus.puck_x, 32'd211);
    check("both_y", bus.puck_y, 32'd450);
    check("both_vx", bus.vel_x, 32'h1A);
    check("both_vy", bus.vel_y, 32'h1B);

    // Second tick 3 cycles into a frame is dropped and flagged
    check("ovr_before", bus.overrun, 32'd0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("ovr_flag", bus.overrun, 32'd1);
    check("ovr_x", bus.puck_x, 32'd205);
    check("ovr_y", bus.puck_y, 32'd445);
    check("ovr_busy", bus.busy, 32'd0);

    // Next frame bounces off the left wall at speed 6
    run_frames(1);
    check("lwall2_x", bus.puck_x, 32'd204);
    check("lwall2_y", bus.puck_y, 32'd440);
    check("lwall2_vx", bus.vel_x, 32'd6);

    // Reset in the middle of a frame
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("midrst_x", bus.puck_x, 32'd464);
    check("midrst_y", bus.puck_y, 32'd271);
    check("midrst_flags", {bus.goal, bus.busy, bus.overrun, bus.game_over}, 32'd0);
    check("midrst_score2", bus.score_2, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Seven right-side goals for player 1
    for (int g = 1; g <= 7; g++) begin
      do_serve();
      run_frames(39);
      set_pads(10'd580, 10'd355, 10'd0, 10'd0);
      run_frames(1);
      set_pads(10'd0, 10'd0, 10'd0, 10'd0);
      if (g == 1) begin
        check("g1_hit_vx", bus.vel_x, 32'd4);
        check("g1_hit_vy", bus.vel_y, 32'h1D);
      end
      run_frames(34);
      if (g == 1) begin
        check("g1_pre_x", bus.puck_x, 32'd720);
        check("g1_pre_y", bus.puck_y, 32'd249);
      end
      goal_seen = 0;
      run_frames(1);
      check("rgoal_pulse", goal_seen, 32'd1);
      check("rgoal_score1", bus.score_1, 32'(g));
      check("rgoal_over", bus.game_over, (g == 7) ? 32'd1 : 32'd0);
    end
    check("over_score2", bus.score_2, 32'd0);

    // Game over: serve and ticks are ignored
    do_serve();
    busy_seen = 0;
    goal_seen = 0;
    run_frames(2);
    check("over_busy", busy_seen, 32'd0);
    check("over_goal", goal_seen, 32'd0);
    check("over_x", bus.puck_x, 32'd464);
    check("over_v", {bus.vel_x, bus.vel_y}, 32'd0);
    check("over_flag", bus.game_over, 32'd1);
    check("over_overrun", bus.overrun, 32'd0);
    check("over_hold_score", bus.score_1, 32'd7);

    // Only reset leaves the game-over state
    clr_n = 1'b0;
    #1;
    check("over_rst_flag", bus.game_over, 32'd0);
    check("over_rst_score", bus.score_1, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
